// File: rtl/amstrad_mmu_cfg_writer.sv
// rtl/amstrad_mmu_cfg_writer.sv - replays MRER/RMR2/RAM-map/ROM-select I/O writes into the MMU
// Latches a target config on start, requests the bus, then issues timed io_WR strobes.
module amstrad_mmu_cfg_writer #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 4
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        start,
    input  logic        plus_mode,
    input  logic [7:0]  ram_cfg,
    input  logic [7:0]  rom_sel,
    input  logic [7:0]  mrer,
    input  logic [7:0]  rmr2,
    input  logic        bus_gnt,
    output logic        bus_req,
    output logic        io_WR,
    output logic [15:0] A,
    output logic [7:0]  D,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [3:0] PULSE_LD = 4'(PULSE_LEN - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_LEN - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [1:0]  idx;
    logic [1:0]  idx_nxt;

    logic        plus_q;
    logic [5:0]  ram_q;
    logic [7:0]  rom_q;
    logic [4:0]  mrer_q;
    logic [4:0]  rmr2_q;

    logic [15:0] item_a;
    logic [7:0]  item_d;
    logic        active;
    logic        unused_bits;

    assign unused_bits = ^{ram_cfg[7:6], mrer[7:5], rmr2[7:5], plus_q};

    // Item 0/1 exist only in plus mode; non-plus sequences start at index 2.
    always_comb begin
        item_a = 16'h7F00;
        item_d = 8'h00;
        case (idx)
            2'd0:    item_d = {3'b100, mrer_q};
            2'd1:    item_d = {3'b101, rmr2_q};
            2'd2:    item_d = {2'b11, ram_q};
            default: begin
                item_a = 16'hDF00;
                item_d = rom_q;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_REQ;
                    idx_nxt   = plus_mode ? 2'd0 : 2'd2;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                // Losing the grant here retries the same item without strobing.
                state_nxt = bus_gnt ? S_STROBE : S_REQ;
            end
            S_STROBE: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == 4'd0) begin
                    if (idx == 2'd3) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = idx + 2'd1;
                        state_nxt = bus_gnt ? S_SETUP : S_REQ;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        if (state_nxt != state) begin
            if (state_nxt == S_STROBE) begin
                cnt_nxt = PULSE_LD;
            end else if (state_nxt == S_GAP) begin
                cnt_nxt = GAP_LD;
            end else begin
                cnt_nxt = 4'd0;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            idx   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            plus_q <= 1'b0;
            ram_q  <= 6'd0;
            rom_q  <= 8'd0;
            mrer_q <= 5'd0;
            rmr2_q <= 5'd0;
        end else if (state == S_IDLE && start) begin
            plus_q <= plus_mode;
            ram_q  <= ram_cfg[5:0];
            rom_q  <= rom_sel;
            mrer_q <= mrer[4:0];
            rmr2_q <= rmr2[4:0];
        end
    end

    // Outputs decode from registered state so reset clears them asynchronously.
    assign active  = (state == S_SETUP) || (state == S_STROBE) || (state == S_GAP);
    assign bus_req = (state == S_REQ) || active;
    assign busy    = (state == S_REQ) || active;
    assign io_WR   = (state == S_STROBE);
    assign done    = (state == S_DONE);
    assign A       = active ? item_a : 16'h0000;
    assign D       = active ? item_d : 8'h00;

endmodule

// File: doc/amstrad_mmu_cfg_writer.md
Name: amstrad_mmu_cfg_writer

Overview:
- Bus initiator that replays memory-configuration I/O writes into the MMU after a snapshot load or a core-side restore.
- Latches a target configuration on `start`, requests the CPU bus, then issues a fixed sequence of write strobes:
  - Plus only: MRER and RMR2 to 7Fxxh.
  - Always: RAM map to 7Fxxh, then ROM select to DFxxh.
- Its A/D/io_WR outputs are muxed onto the MMU's I/O write inputs while it holds the bus grant.

Parameters:
- PULSE_LEN, 4: cycles io_WR held high per write (1..15).
- GAP_LEN, 4: cycles io_WR held low after each strobe, with A/D stable (1..15).

Ports:
- CLK  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sequence.
- plus_mode  in  1  sampled on start; when 1, the MRER and RMR2 writes are included.
- ram_cfg  in  8  RAM map value; bits [5:0] used.
- rom_sel  in  8  ROM select value.
- mrer  in  8  MRER value; bits [4:0] used.
- rmr2  in  8  RMR2 value; bits [4:0] used.
- bus_gnt  in  1  arbiter grant; the bus is owned while this is high.
- bus_req  out  1  bus request to the arbiter.
- io_WR  out  1  write strobe to the MMU.
- A  out  16  I/O address.
- D  out  8  I/O data.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: asynchronous, active-low on reset_n, CLK single clock domain. While reset_n=0 all outputs are 0 and the FSM is in IDLE. Reset mid-strobe drops io_WR immediately; no partial-write recovery.
- Input latching: on start in IDLE, latch plus_mode, ram_cfg, rom_sel, mrer, rmr2. Changes after that are ignored until the next sequence. start while busy=1 is ignored.
- Write list, in order, 16-bit address / data byte:
  1. Plus only: 7F00h / {100b, mrer[4:0]}.
  2. Plus only: 7F00h / {101b, rmr2[4:0]}.
  3. Always: 7F00h / {11b, ram_cfg[5:0]}.
  4. Always: DF00h / rom_sel.
- Item count is 4 in plus mode and 2 otherwise. The item index is 2 bits and starts at 0 (plus) or 2 (non-plus).
- FSM states:
  - IDLE: all outputs 0. On start → REQ; busy=1 from the next edge.
  - REQ: bus_req=1, io_WR=0. When bus_gnt=1 → SETUP.
  - SETUP (1 cycle): drive A/D for the current item, io_WR=0 → STROBE.
  - STROBE (PULSE_LEN cycles): io_WR=1, A/D held → GAP.
  - GAP (GAP_LEN cycles): io_WR=0, A/D held. At the end:
    - last item → DONE;
    - else if bus_gnt=1 → SETUP with index+1;
    - else → REQ with index+1.
  - DONE (1 cycle): done=1, busy=0, bus_req=0, A=0, D=0 → IDLE.
- bus_req stays 1 from REQ through the GAP of the last item.
- bus_gnt loss:
  - During SETUP: return to REQ without strobing; the same item is retried.
  - During STROBE or GAP: the current write completes. The next item waits in REQ.
- A/D stability: A and D never change while io_WR=1 or during the cycle before io_WR rises.
- Timing: exactly one 0→1 io_WR edge per item.
  - Per-item cost with continuous grant: 1+PULSE_LEN+GAP_LEN cycles.
  - Sequence length with grant already high: 1 (REQ) + N·(1+PULSE_LEN+GAP_LEN) + 1 (DONE).
  - Defaults: 20 cycles non-plus, 38 cycles plus.
- Counters: one 4-bit cycle counter, reloaded on every state entry. No arithmetic wrap is possible within the parameter ranges.

Test Plan:
- Non-plus, defaults, bus_gnt tied 1; start with ram_cfg=C4h, rom_sel=07h →
  - io_WR rises twice: first A=7F00h D=C4h, then A=DF00h D=07h;
  - each pulse is 4 cycles high;
  - done pulses 20 cycles after start; MMU model shows RAMmap=4, ROMbank=7.
- Plus mode, mrer=8Dh, rmr2=B3h, ram_cfg=C0h, rom_sel=00h → four strobes in order: D=8Dh, B3h, C0h, 00h; addresses 7F00h ×3 then DF00h; done at cycle 38.
- bus_gnt held low 10 cycles after start → bus_req=1 with io_WR=0 throughout. The first strobe begins 2 cycles after the grant rises.
- Drop bus_gnt mid-STROBE of item 1 → that strobe completes its full 4 cycles, FSM sits in REQ, and the remaining items resume after the re-grant with no duplicate strobe.
- Pulse start again while busy, and change ram_cfg mid-sequence → no effect; the sequence uses the originally latched values and produces exactly one done.
- Assert reset_n=0 during STROBE → io_WR, bus_req, busy, A and D go to 0 asynchronously (before the next CLK edge). After release the block is IDLE, and a new start runs the full sequence.
